and2_triple: RTL and testbench

- Two-input AND block that builds the same function three ways and checks them against each other.
  - Gate-primitive style.
  - Continuous-assignment (dataflow) style.
  - Procedural (behavioural) style.
- All three combinational outputs are exposed for equivalence testing.
- A clocked layer registers a 2-of-3 voted result, flags any disagreement between styles, and counts disagreements.
- Sits in the basic-gates library as the reference/self-checking AND cell.

---
 rtl/gates_pkg.sv | 11 +
 rtl/and2_vote.sv | 41 ++++
 rtl/and2_triple.sv | 50 +++++
 tb/tb_and2_triple.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gates_pkg.sv
// Shared definitions for the basic-gates library: default counter width and
// the 2-of-3 majority helper used by the voting layers.
package gates_pkg;

    localparam int CNT_W_DEFAULT = 8;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (y & z) | (x & z);
    endfunction

endpackage

// File: rtl/and2_vote.sv
// Registered voter for the three AND styles: majority output, disagreement
// flag and a saturating disagreement counter.
module and2_vote
    import gates_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_g,
    input  logic             y_d,
    input  logic             y_b,
    output logic             y_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    logic disagree;

    // Case equality so that an x in one style and not another still counts
    // as a disagreement in simulation.
    always_comb begin
        disagree = 1'b0;
        if (!((y_g === y_d) && (y_d === y_b)))
            disagree = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            y_q      <= maj3(y_g, y_d, y_b);
            mismatch <= disagree;
            if (disagree && (err_cnt != {CNT_W{1'b1}}))
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/and2_triple.sv
// Reference AND cell: the same 2-input AND built as a gate primitive, a
// continuous assignment and a procedural block, cross-checked by and2_vote.
module and2_triple
    import gates_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             y_g,
    output logic             y_d,
    output logic             y_b,
    output logic             y_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    wire  y_g_int;
    wire  y_d_int;
    logic y_b_int;

    and g_and (y_g_int, a, b);

    assign y_d_int = a & b;

    // The & operator keeps x/z propagation identical to the other two styles.
    always_comb begin
        y_b_int = a & b;
    end

    assign y_g = y_g_int;
    assign y_d = y_d_int;
    assign y_b = y_b_int;

    and2_vote #(
        .CNT_W(CNT_W)
    ) u_vote (
        .clk     (clk),
        .rst     (rst),
        .y_g     (y_g_int),
        .y_d     (y_d_int),
        .y_b     (y_b_int),
        .y_q     (y_q),
        .mismatch(mismatch),
        .err_cnt (err_cnt)
    );

endmodule

// File: tb/tb_and2_triple.sv
// Directed self-checking bench for and2_triple with a 2-bit counter so that
// saturation is reached quickly.
module tb_and2_triple;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             a;
    logic             b;
    logic             y_g;
    logic             y_d;
    logic             y_b;
    logic             y_q;
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt;

    int nVectors;
    int nMiscompares;

    and2_triple #(
        .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .y_g     (y_g),
        .y_d     (y_d),
        .y_b     (y_b),
        .y_q     (y_q),
        .mismatch(mismatch),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic bv);
        a = av;
        b = bv;
        #1;
    endtask

    task automatic checkComb(input string tag, input logic exp);
        checkOutput({tag, "_g"}, y_g, exp);
        checkOutput({tag, "_d"}, y_d, exp);
        checkOutput({tag, "_b"}, y_b, exp);
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sweepIn  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic       sweepExp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       xbit;
    logic [1:0] cntExp;

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        xbit         = 1'bx;
        rst          = 1'b1;
        a            = 1'b0;
        b            = 1'b0;

        // Combinational truth table while the registered layer is held in reset.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = sweepIn[i];
            applyStimulus(v[1], v[0]);
            checkComb($sformatf("tt%0d", i), sweepExp[i]);
        end
        checkOutput("rst_yq", y_q, 1'b0);
        checkOutput("rst_mm", mismatch, 1'b0);
        checkOutput("rst_cnt", err_cnt, 2'd0);

        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("pre_edge_yq", y_q, 1'b0);
        stepClock();
        checkOutput("first_yq", y_q, 1'b1);
        checkOutput("first_mm", mismatch, 1'b0);

        // Asynchronous reset pulse between edges.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_yq", y_q, 1'b0);
        checkComb("async_comb", 1'b1);
        @(negedge clk);
        rst = 1'b0;
        stepClock();
        checkOutput("rel_yq", y_q, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        stepClock();
        checkOutput("a0_yq", y_q, 1'b0);

        // Unknown operand handling.
        @(negedge clk);
        applyStimulus(1'b0, xbit);
        checkComb("zero_x", 1'b0);
        applyStimulus(1'b1, xbit);
        checkComb("one_x", xbit);
        stepClock();
        checkOutput("one_x_mm", mismatch, 1'b0);
        checkOutput("one_x_cnt", err_cnt, 2'd0);

        // Inject a fault in the dataflow style and watch the counter saturate.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        force dut.y_d_int = 1'b1;
        cntExp = 2'd0;
        for (int i = 1; i <= 5; i++) begin
            stepClock();
            if (cntExp != 2'd3) cntExp = cntExp + 2'd1;
            checkOutput($sformatf("flt%0d_mm", i), mismatch, 1'b1);
            checkOutput($sformatf("flt%0d_cnt", i), err_cnt, cntExp);
            checkOutput($sformatf("flt%0d_yq", i), y_q, 1'b0);
        end

        // Reset while saturated and flagged clears immediately.
        #3;
        rst = 1'b1;
        #1;
        checkOutput("sat_rst_mm", mismatch, 1'b0);
        checkOutput("sat_rst_cnt", err_cnt, 2'd0);
        release dut.y_d_int;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        stepClock();
        checkOutput("clean_mm", mismatch, 1'b0);
        checkOutput("clean_cnt", err_cnt, 2'd0);
        checkOutput("clean_yq", y_q, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
